// File: rtl/digital_tube_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan controller.
package digital_tube_scan_ctrl_pkg;

  localparam int unsigned clkFreq_FPGA     = 27_000_000;
  localparam int unsigned PARAM_NUM_DIGITS = 4;

  typedef logic [PARAM_NUM_DIGITS-1:0] digital_tube_t;
  typedef logic [7:0]                  seg_pattern_t;

  typedef enum logic {
    SCAN_ON,
    SCAN_GUARD
  } scan_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digital_tube_scan_ctrl_if.sv
// Producer-side write channel: one display word plus decimal points, valid/ready handshake.
interface digital_tube_scan_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;

  modport master (output wr_valid, output wr_data, output wr_dp, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_dp, output wr_ready);
endinterface

// File: rtl/digital_tube_scan_ctrl_seven_seg_decode.sv
// Hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seven_seg_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/digital_tube_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display with frame-synchronous word commit.
// Optional leading-zero blanking is enabled by defining DIGITAL_TUBE_LZB_EN.
module digital_tube_scan_ctrl
  import digital_tube_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = clkFreq_FPGA,
  parameter int unsigned TICK_HZ     = 100_000,
  parameter int unsigned ON_TICKS    = 90,
  parameter int unsigned GUARD_TICKS = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  digital_tube_scan_ctrl_if.slave        wr,
  input  logic                           disp_en,
  output digital_tube_t                  tube_enable,
  output seg_pattern_t                   segment_out,
  output logic                           frame_done
);
  localparam int unsigned DIV     = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(max_u(ON_TICKS, GUARD_TICKS) + 1);
  localparam int unsigned IDX_W   = $clog2(PARAM_NUM_DIGITS);
  localparam int unsigned WORD_W  = 4 * PARAM_NUM_DIGITS;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   ON_LAST    = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'(GUARD_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(PARAM_NUM_DIGITS - 1);

  logic [PRESC_W-1:0]          presc_reg;
  logic                        tick;
  scan_state_t                 state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [IDX_W-1:0]            idx_reg, idx_next;
  logic                        boundary;
  logic [WORD_W-1:0]           active_reg, active_next, pending_reg;
  logic [PARAM_NUM_DIGITS-1:0] active_dp_reg, active_dp_next, pending_dp_reg;
  logic                        pending_full_reg;
  logic                        accept, commit, show, blank;
  logic [3:0]                  digit_nib [PARAM_NUM_DIGITS];
  logic [6:0]                  dec_seg;
  digital_tube_t               en_next;
  seg_pattern_t                seg_next;

  assign tick = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PRESC_W'(1);
    end
  end

  // The counter stays 0 only until the first tick after reset; entering a state loads 1
  // because the entering tick already counts as the first tick of that state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    boundary   = 1'b0;
    if (tick) begin
      case (state_reg)
        SCAN_ON: begin
          if (cnt_reg == ON_LAST) begin
            state_next = SCAN_GUARD;
            cnt_next   = CNT_ONE;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        SCAN_GUARD: begin
          if (cnt_reg == GUARD_LAST) begin
            state_next = SCAN_ON;
            cnt_next   = CNT_ONE;
            idx_next   = idx_reg + IDX_W'(1);
            boundary   = (idx_reg == IDX_LAST);
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: state_next = SCAN_ON;
      endcase
    end
  end

  assign accept         = wr.wr_valid && !pending_full_reg;
  assign commit         = boundary && pending_full_reg;
  assign active_next    = commit ? pending_reg : active_reg;
  assign active_dp_next = commit ? pending_dp_reg : active_dp_reg;
  assign wr.wr_ready    = !pending_full_reg;

  for (genvar gi = 0; gi < PARAM_NUM_DIGITS; gi++) begin : g_nib
    assign digit_nib[gi] = active_next[4*gi +: 4];
  end

  seven_seg_decode u_decode (
    .hex (digit_nib[idx_next]),
    .seg (dec_seg)
  );

`ifdef DIGITAL_TUBE_LZB_EN
  logic [PARAM_NUM_DIGITS-1:0] upper_zero;
  for (genvar gi = 0; gi < PARAM_NUM_DIGITS; gi++) begin : g_lzb
    assign upper_zero[gi] = (active_next[WORD_W-1:4*gi] == '0);
  end
  assign blank = (idx_next != '0) && upper_zero[idx_next];
`else
  assign blank = 1'b0;
`endif

  assign show     = disp_en && (state_next == SCAN_ON) && (cnt_next != '0);
  assign en_next  = show ? (digital_tube_t'(1) << idx_next) : '0;
  assign seg_next = show ? {active_dp_next[idx_next], (blank ? 7'h00 : dec_seg)} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= SCAN_ON;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      active_reg       <= '0;
      active_dp_reg    <= '0;
      pending_reg      <= '0;
      pending_dp_reg   <= '0;
      pending_full_reg <= 1'b0;
      tube_enable      <= '0;
      segment_out      <= '0;
      frame_done       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      active_reg    <= active_next;
      active_dp_reg <= active_dp_next;
      tube_enable   <= en_next;
      segment_out   <= seg_next;
      frame_done    <= boundary;
      if (accept) begin
        pending_reg      <= wr.wr_data;
        pending_dp_reg   <= wr.wr_dp;
        pending_full_reg <= 1'b1;
      end else if (commit) begin
        pending_full_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digital_tube_scan_ctrl.sv
// Randomized self-checking bench: expected display derived from elapsed time since reset.
module tb_digital_tube_scan_ctrl;
  import digital_tube_scan_ctrl_pkg::*;

  localparam int CLK_HZ  = 100;
  localparam int TICK    = 50;
  localparam int ON_T    = 3;
  localparam int GUARD_T = 1;
  localparam int DIV     = CLK_HZ / TICK;
  localparam int SLOT    = DIV * (ON_T + GUARD_T);
  localparam int ON_CLK  = DIV * ON_T;
  localparam int FRAME   = SLOT * PARAM_NUM_DIGITS;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          disp_en = 1'b1;
  digital_tube_t tube_enable;
  seg_pattern_t  segment_out;
  logic          frame_done;

  digital_tube_scan_ctrl_if wr_if ();

  digital_tube_scan_ctrl #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TICK_HZ     (TICK),
    .ON_TICKS    (ON_T),
    .GUARD_TICKS (GUARD_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr_if),
    .disp_en     (disp_en),
    .tube_enable (tube_enable),
    .segment_out (segment_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what is on display, what is waiting, edges since reset release.
  int          m_edges    = 0;
  logic [15:0] m_active   = '0;
  logic [15:0] m_pend     = '0;
  logic [3:0]  m_active_dp = '0;
  logic [3:0]  m_pend_dp  = '0;
  bit          m_full     = 1'b0;
  bit          m_boundary = 1'b0;
  logic [6:0]  seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input int d);
    logic [3:0] nib;
    logic       blank;
    nib   = m_active[4*d +: 4];
    blank = 1'b0;
`ifdef DIGITAL_TUBE_LZB_EN
    blank = (d != 0) && ((m_active >> (4*d)) == 16'h0);
`endif
    return {m_active_dp[d], (blank ? 7'h00 : seg_lut[nib])};
  endfunction

  task automatic compare_outputs(input bit en);
    int         p, slot, d;
    logic [3:0] e_en;
    logic [7:0] e_seg;
    p     = m_edges - 2;
    e_en  = '0;
    e_seg = '0;
    if (p >= 0) begin
      slot = p % FRAME;
      d    = slot / SLOT;
      if (((slot % SLOT) < ON_CLK) && en) begin
        e_en  = 4'(1 << d);
        e_seg = model_seg(d);
      end
    end
    check("tube_enable", 32'(tube_enable), 32'(e_en));
    check("segment_out", 32'(segment_out), 32'(e_seg));
    check("frame_done", 32'(frame_done), 32'(m_boundary));
    check("wr_ready", 32'(wr_if.wr_ready), 32'(!m_full));
  endtask

  task automatic cycle(input bit valid, input logic [15:0] data, input logic [3:0] dp,
                       input bit en, output bit accepted);
    bit was_full;
    int p;
    wr_if.wr_valid = valid;
    wr_if.wr_data  = data;
    wr_if.wr_dp    = dp;
    disp_en        = en;
    @(posedge clk);
    accepted   = 1'b0;
    m_edges++;
    p          = m_edges - 2;
    m_boundary = (p > 0) && ((p % FRAME) == 0);
    was_full   = m_full;
    if (m_boundary && was_full) begin
      m_active    = m_pend;
      m_active_dp = m_pend_dp;
      m_full      = 1'b0;
    end
    if (valid && !was_full) begin
      m_pend    = data;
      m_pend_dp = dp;
      m_full    = 1'b1;
      accepted  = 1'b1;
    end
    #1;
    compare_outputs(en);
    if (accepted) $display("WR accepted data=%h dp=%b edge=%0d", data, dp, m_edges);
  endtask

  task automatic idle(input int n, input bit en);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, en, acc);
  endtask

  task automatic send(input logic [15:0] data, input logic [3:0] dp);
    bit acc;
    int n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 4 * FRAME) begin
      cycle(1'b1, data, dp, 1'b1, acc);
      n++;
    end
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic pulse_reset(input int hold);
    wr_if.wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i <= hold; i++) begin
      check("rst_tube_enable", 32'(tube_enable), 32'd0);
      check("rst_segment_out", 32'(segment_out), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
      if (i < hold) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    rst_n       = 1'b1;
    m_edges     = 0;
    m_active    = '0;
    m_active_dp = '0;
    m_full      = 1'b0;
    m_boundary  = 1'b0;
    $display("RESET released at %0t", $time);
  endtask

  initial begin
    logic [15:0] rnd_data;
    logic [3:0]  rnd_dp;
    bit          rnd_valid, acc, en;
    int          n;

    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_dp    = '0;
    #2;
    pulse_reset(2);
    idle(2 * FRAME + 6, 1'b1);

    idle(13, 1'b1);
    send(16'h1234, 4'b0010);
    idle(2 * FRAME, 1'b1);

    send(16'hAAAA, 4'b0000);
    send(16'h5555, 4'b1111);
    idle(3 * FRAME, 1'b1);

    idle(11, 1'b1);
    $display("DISP_EN low for 10 clk at %0t", $time);
    idle(10, 1'b0);
    idle(2 * FRAME, 1'b1);

    rnd_valid = 1'b0;
    rnd_data  = 16'($urandom);
    rnd_dp    = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      if (!rnd_valid) rnd_valid = ($urandom_range(0, 2) == 0);
      en = ($urandom_range(0, 7) != 0);
      cycle(rnd_valid, rnd_data, rnd_dp, en, acc);
      if (acc) begin
        rnd_valid = 1'b0;
        rnd_data  = 16'($urandom);
        rnd_dp    = 4'($urandom);
      end
    end
    idle(1, 1'b1);

    n = 0;
    while (m_full && n < 2 * FRAME) begin
      idle(1, 1'b1);
      n++;
    end
    n = 0;
    while (((m_edges - 2) % FRAME) != 2 * SLOT && n < 2 * FRAME) begin
      idle(1, 1'b1);
      n++;
    end
    send(16'hBEEF, 4'b1010);
    check("digit2_on_before_reset", 32'(tube_enable), 32'h4);
    pulse_reset(3);
    idle(3 * FRAME, 1'b1);

    send(16'h0070, 4'b0000);
    idle(2 * FRAME + 8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
